// File: rtl/ccm_ctr_pack.sv
// Packs the ccm_ctr ciphertext byte stream into MSB-first 128-bit blocks behind a 2-entry FIFO.
// Define CCM_CTR_PACK_OVF_EN to implement the sticky out_overflow flag; otherwise it is tied to 0.
module ccm_ctr_pack #(
   parameter int WIDTH       = 8,
   parameter int WIDTH_BLOCK = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_en,
   input  logic [WIDTH-1:0]       in_data_length,
   output logic [WIDTH_BLOCK-1:0] out_block,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic [4:0]             out_byte_cnt,
   output logic                   out_overflow
);

   localparam int          NBYTES = WIDTH_BLOCK / WIDTH;
   localparam int          RW     = WIDTH - 3;
   localparam logic [4:0]  NB     = 5'(NBYTES);

   typedef enum logic {IDLE, COLLECT} state_e;

   typedef struct packed {
      logic [WIDTH_BLOCK-1:0] blk;
      logic                   last;
      logic [4:0]             cnt;
   } entry_t;

   state_e                 state_q, state_d;
   logic [RW-1:0]          rem_q, rem_d, cur_rem, rem_n;
   logic [4:0]             slot_q, slot_d, idx, slot_n;
   logic [WIDTH_BLOCK-1:0] asm_q, asm_d, block_n;
   logic                   accept, push, push_ok, pop;
   logic                   len_unused;

   entry_t                 mem_q [2];
   entry_t                 wr_entry;
   logic                   wr_q, rd_q;
   logic [1:0]             count_q;

   // Residual (non-byte) length bits are deliberately ignored.
   assign len_unused = ^in_data_length[2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         slot_q  <= '0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         slot_q  <= slot_d;
         asm_q   <= asm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      slot_d  = slot_q;
      asm_d   = asm_q;
      if (accept) begin
         rem_d = rem_n;
         if (push) begin
            asm_d   = '0;
            slot_d  = '0;
            state_d = (rem_n == '0) ? IDLE : COLLECT;
         end else begin
            asm_d   = block_n;
            slot_d  = slot_n;
            state_d = COLLECT;
         end
      end
   end

   // In IDLE the byte count comes straight from the length input and lands in slot 0.
   always_comb begin
      cur_rem = (state_q == IDLE) ? in_data_length[WIDTH-1:3] : rem_q;
      idx     = (state_q == IDLE) ? 5'd0 : slot_q;
      accept  = in_en && (cur_rem != '0);
      rem_n   = cur_rem - RW'(1);
      slot_n  = idx + 5'd1;
      block_n = asm_q;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (idx == 5'(i)) block_n[WIDTH_BLOCK-1-WIDTH*i -: WIDTH] = in_data;
      end
      push    = accept && ((slot_n == NB) || (rem_n == '0));
   end

   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign push_ok   = push && ((count_q != 2'd2) || pop);
   assign wr_entry  = '{blk: block_n, last: (rem_n == '0), cnt: slot_n};

   // When full with a simultaneous pop, wr_q == rd_q: the write reuses the slot being vacated.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= wr_entry;
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop};
      end
   end

   assign out_block    = mem_q[rd_q].blk;
   assign out_last     = mem_q[rd_q].last;
   assign out_byte_cnt = mem_q[rd_q].cnt;

`ifdef CCM_CTR_PACK_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (reset) ovf_q <= 1'b0;
      else if (push && !push_ok) ovf_q <= 1'b1;
   end
   assign out_overflow = ovf_q;
`else
   assign out_overflow = 1'b0;
`endif

endmodule
